// File: rtl/alu_operand_entry.sv
// alu_operand_entry: push-button operand sequencer for the ALU/display datapath.
// Two bouncy buttons are synchronized and debounced. Each accepted "next" press
// captures the shared switch bank into A, then B, then op. A "clear" press
// empties all fields. Opcodes above 4'b1100 are refused and flagged.

// AluOperandDebounce: 2-flop synchronizer, level debouncer and press-edge detector
module AluOperandDebounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             prevStable_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter runs only while the synced level disagrees with the accepted
    // level. Any return to agreement, however brief, restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and previous accepted level for edge detection
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            prevStable_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            prevStable_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // A press is the single cycle in which the accepted level has just risen.
    // Releases and long holds produce nothing further.
    assign press_o = stable_q & ~prevStable_q;

endmodule

// alu_operand_entry: top-level entry sequencer
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] op,
    output logic [1:0] stage,
    output logic       valid,
    output logic       start,
    output logic       op_err
);

    // Highest opcode the ALU implements
    localparam logic [3:0] OP_MAX = 4'b1100;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] op_q;
    logic       valid_q;
    logic       start_q;
    logic       opErr_q;
    logic       nextEvt;
    logic       clearEvt;

    AluOperandDebounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_nextDebounce (
        .clock  (clock),
        .rst    (rst),
        .btn_i  (btn_next),
        .press_o(nextEvt)
    );

    AluOperandDebounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clearDebounce (
        .clock  (clock),
        .rst    (rst),
        .btn_i  (btn_clear),
        .press_o(clearEvt)
    );

    // Entry sequencer: clear overrides everything, including a next press in the
    // same cycle (that press is dropped). start is asserted only on the step
    // from S_OP into S_RUN and falls back on the following cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= S_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 4'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            opErr_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (clearEvt) begin
                state_q <= S_A;
                a_q     <= 4'd0;
                b_q     <= 4'd0;
                op_q    <= 4'd0;
                valid_q <= 1'b0;
                opErr_q <= 1'b0;
            end else if (nextEvt) begin
                case (state_q)
                    S_A: begin
                        a_q     <= sw;
                        state_q <= S_B;
                    end
                    S_B: begin
                        b_q     <= sw;
                        state_q <= S_OP;
                    end
                    S_OP: begin
                        if (sw <= OP_MAX) begin
                            op_q    <= sw;
                            opErr_q <= 1'b0;
                            valid_q <= 1'b1;
                            start_q <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            opErr_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        a_q     <= sw;
                        valid_q <= 1'b0;
                        opErr_q <= 1'b0;
                        state_q <= S_B;
                    end
                    default: begin
                        state_q <= S_A;
                    end
                endcase
            end
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign op     = op_q;
    assign stage  = state_q;
    assign valid  = valid_q;
    assign start  = start_q;
    assign op_err = opErr_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: directed bench for the operand entry sequencer with a
// short debounce window. Inputs change and outputs are observed on the falling
// clock edge, well away from the rising edge where the design updates.
module tb_alu_operand_entry;

    logic       clock;
    logic       rst;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clear;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] op;
    logic [1:0] stage;
    logic       valid;
    logic       start;
    logic       op_err;

    int testCount;
    int failCount;

    alu_operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .sw       (sw),
        .btn_next (btn_next),
        .btn_clear(btn_clear),
        .A        (A),
        .B        (B),
        .op       (op),
        .stage    (stage),
        .valid    (valid),
        .start    (start),
        .op_err   (op_err)
    );

    // Free-running 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it, and on mismatch counts the failure and reports it
    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive switches and buttons, then hold for the press latency (2 sync +
    // 4 debounce cycles to the event, plus one edge to capture)
    task automatic applyStimulus(input logic [3:0] swVal, input logic nextB, input logic clearB);
        @(negedge clock);
        sw        = swVal;
        btn_next  = nextB;
        btn_clear = clearB;
        repeat (7) @(negedge clock);
    endtask

    // Release both buttons and let the release settle through the debouncer
    task automatic releaseButtons();
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    // Checks the whole operand set in one go
    task automatic checkAll(input string tag, input logic [3:0] eA, input logic [3:0] eB,
                            input logic [3:0] eOp, input logic [1:0] eStage,
                            input logic eValid, input logic eErr);
        checkOutput({tag, ".A"},      A,              eA);
        checkOutput({tag, ".B"},      B,              eB);
        checkOutput({tag, ".op"},     op,             eOp);
        checkOutput({tag, ".stage"},  {2'b00, stage}, {2'b00, eStage});
        checkOutput({tag, ".valid"},  {3'b000, valid},  {3'b000, eValid});
        checkOutput({tag, ".op_err"}, {3'b000, op_err}, {3'b000, eErr});
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b0;
        sw        = 4'h0;
        btn_next  = 1'b0;
        btn_clear = 1'b0;

        // Reset held while the buttons toggle: nothing may move
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            btn_next  = ~btn_next;
            btn_clear = (i % 3) == 0;
        end
        checkAll("reset", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        checkOutput("reset.start", {3'b000, start}, 4'h0);
        @(negedge clock);
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        repeat (12) @(negedge clock);
        checkAll("postReset", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

        // Five 3-cycle glitches must all be rejected
        sw = 4'h9;
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            repeat (3) @(negedge clock);
            btn_next = 1'b0;
            repeat (4) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        checkOutput("bounce.stage", {2'b00, stage}, 4'h0);
        checkOutput("bounce.A", A, 4'h0);

        // A 10-cycle hold: event after 6 cycles, captured on the 7th edge
        btn_next = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("latency.stageBefore", {2'b00, stage}, 4'h0);
        @(negedge clock);
        checkOutput("latency.stageAfter", {2'b00, stage}, 4'h1);
        checkOutput("latency.A", A, 4'h9);
        repeat (3) @(negedge clock);
        releaseButtons();
        checkOutput("hold.oneEvent", {2'b00, stage}, 4'h1);

        // Complete the entry: B=3, op=2
        applyStimulus(4'h3, 1'b1, 1'b0);
        releaseButtons();
        checkAll("entryB", 4'h9, 4'h3, 4'h0, 2'd2, 1'b0, 1'b0);
        checkOutput("entryB.start", {3'b000, start}, 4'h0);
        applyStimulus(4'h2, 1'b1, 1'b0);
        checkAll("entryOp", 4'h9, 4'h3, 4'h2, 2'd3, 1'b1, 1'b0);
        checkOutput("entryOp.startHigh", {3'b000, start}, 4'h1);
        @(negedge clock);
        checkOutput("entryOp.startLow", {3'b000, start}, 4'h0);
        checkOutput("entryOp.validHeld", {3'b000, valid}, 4'h1);
        releaseButtons();

        // Re-entry from S_RUN: new A, old B and op kept
        applyStimulus(4'h7, 1'b1, 1'b0);
        releaseButtons();
        checkAll("reentry", 4'h7, 4'h3, 4'h2, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'h4, 1'b1, 1'b0);
        releaseButtons();
        checkAll("reentryB", 4'h7, 4'h4, 4'h2, 2'd2, 1'b0, 1'b0);

        // Illegal opcode D is refused and flagged, legal C then accepted
        applyStimulus(4'hD, 1'b1, 1'b0);
        releaseButtons();
        checkAll("illegalOp", 4'h7, 4'h4, 4'h2, 2'd2, 1'b0, 1'b1);
        checkOutput("illegalOp.start", {3'b000, start}, 4'h0);
        applyStimulus(4'hC, 1'b1, 1'b0);
        checkOutput("legalOp.start", {3'b000, start}, 4'h1);
        releaseButtons();
        checkAll("legalOp", 4'h7, 4'h4, 4'hC, 2'd3, 1'b1, 1'b0);

        // Clear empties every field
        applyStimulus(4'h5, 1'b0, 1'b1);
        releaseButtons();
        checkAll("clear", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

        // Simultaneous next and clear in S_B: clear wins, B not captured
        applyStimulus(4'h5, 1'b1, 1'b0);
        releaseButtons();
        checkAll("preSimul", 4'h5, 4'h0, 4'h0, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'h6, 1'b1, 1'b1);
        releaseButtons();
        checkAll("simul", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

        // Reset during a debounce count: immediate clear, no event afterwards
        applyStimulus(4'h8, 1'b1, 1'b0);
        releaseButtons();
        checkOutput("preAsync.A", A, 4'h8);
        @(negedge clock);
        sw       = 4'h1;
        btn_next = 1'b1;
        repeat (4) @(negedge clock);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncReset.A", A, 4'h0);
        checkOutput("asyncReset.stage", {2'b00, stage}, 4'h0);
        @(negedge clock);
        btn_next = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b1;
        repeat (15) @(negedge clock);
        checkAll("postAsync", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
